// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and widths for the writeback port arbiter.
//   WARP_W/SCB_W/REG_W/LANES/LANE_W : field widths of a writeback request
//   wb_entry_t                      : one buffered writeback request
//   wb_src_e                        : which producer owns a grant
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WARP_W = 3;
  localparam int SCB_W  = 2;
  localparam int REG_W  = 5;
  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int DATA_W = LANES * LANE_W;

  typedef struct packed {
    logic [WARP_W-1:0] warp_ID;
    logic [SCB_W-1:0]  scb_ID;
    logic [REG_W-1:0]  reg_addr;
    logic [LANES-1:0]  thread_mask;
    logic              reg_write;    // 0 = feedback-only (MEM store)
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  function automatic wb_src_e other_src(input wb_src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t with a combinational head (show-ahead).
// A push into a full FIFO is accepted only when a pop happens the same cycle.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   i_push      : write i_entry at the tail
//   i_entry     : payload to write
//   i_pop       : remove the head (ignored when empty)
//   o_head      : current head entry (valid when o_count != 0)
//   o_full      : registered full flag
//   o_count     : registered occupancy, $clog2(DEPTH)+1 bits (empty = 0)
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  wb_entry_t     i_entry,
  input  logic          i_pop,
  output wb_entry_t     o_head,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, so a reset only has to clear those.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the register-file write port and the scoreboard positive-feedback
// port between the ALU writeback pipe and MEM stage 4. MEM cannot stall, so it
// is buffered and favoured; the ALU side is flow-controlled by alu_ready.
// One grant per cycle; outputs are registered (input edge -> outputs after the
// following edge).
// Optional build macro: WB_ALU_STARVE_EN adds an ALU starvation counter that
// forces an ALU grant after STARVE_LIMIT waiting cycles unless MEM is full.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   alu_valid/alu_ready   : ALU handshake (ready = ALU FIFO not full)
//   alu_*                 : ALU warp/scb/reg/mask/data fields
//   mem_valid             : MEM request, always accepted (dropped if full)
//   mem_reg_write         : 1 = load (RF write), 0 = store (feedback only)
//   mem_*                 : MEM warp/scb/reg/mask/data fields
//   rf_write_o, rf_*_o    : RF write strobe and fields
//   pos_feedback_*_o      : scoreboard release strobe and fields
//   mem_ovf_o             : sticky MEM-drop flag, cleared by reset
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int MEM_HI_WM      = 2
`ifdef WB_ALU_STARVE_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [WARP_W-1:0] alu_warp_ID,
  input  logic [SCB_W-1:0]  alu_scb_ID,
  input  logic [REG_W-1:0]  alu_reg_addr,
  input  logic [LANES-1:0]  alu_thread_mask,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [WARP_W-1:0] mem_warp_ID,
  input  logic [SCB_W-1:0]  mem_scb_ID,
  input  logic [REG_W-1:0]  mem_reg_addr,
  input  logic [LANES-1:0]  mem_thread_mask,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_write_o,
  output logic [WARP_W-1:0] rf_warpID_o,
  output logic [REG_W-1:0]  rf_addr_o,
  output logic [LANES-1:0]  rf_mask_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              pos_feedback_valid_o,
  output logic [WARP_W-1:0] pos_feedback_warpID_o,
  output logic [SCB_W-1:0]  pos_feedback_scbID_o,
  output logic [LANES-1:0]  pos_feedback_mask_o,
  output logic              mem_ovf_o
);

  localparam int ALU_CW = $clog2(ALU_FIFO_DEPTH) + 1;
  localparam int MEM_CW = $clog2(MEM_FIFO_DEPTH) + 1;

  wb_entry_t         w_alu_in, w_mem_in, w_alu_head, w_mem_head, w_head;
  logic              w_alu_full, w_mem_full, w_alu_empty, w_mem_empty;
  logic [ALU_CW-1:0] w_alu_count;
  logic [MEM_CW-1:0] w_mem_count;
  logic              w_alu_push, w_mem_hi, w_alu_force;
  logic              w_grant, w_pop_alu, w_pop_mem;
  wb_src_e           w_src;
  wb_src_e           r_rr;

  logic              r_rf_write, r_fb_valid, r_ovf;
  logic [WARP_W-1:0] r_warp;
  logic [SCB_W-1:0]  r_scb;
  logic [REG_W-1:0]  r_addr;
  logic [LANES-1:0]  r_mask;
  logic [DATA_W-1:0] r_data;

  // ALU entries always write the RF; tagging them here lets the output stage
  // take rf_write straight from the granted entry.
  assign w_alu_in = '{warp_ID: alu_warp_ID, scb_ID: alu_scb_ID, reg_addr: alu_reg_addr,
                      thread_mask: alu_thread_mask, reg_write: 1'b1, data: alu_data};
  assign w_mem_in = '{warp_ID: mem_warp_ID, scb_ID: mem_scb_ID, reg_addr: mem_reg_addr,
                      thread_mask: mem_thread_mask, reg_write: mem_reg_write, data: mem_data};

  // Ready comes from the registered count only, so a full ALU FIFO refuses a
  // push even in a cycle where it is being popped.
  assign alu_ready  = !reset && !w_alu_full;
  assign w_alu_push = alu_valid && alu_ready;

  wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_alu_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_alu_push),
    .i_entry (w_alu_in),
    .i_pop   (w_pop_alu),
    .o_head  (w_alu_head),
    .o_full  (w_alu_full),
    .o_count (w_alu_count)
  );

  wb_fifo #(.DEPTH(MEM_FIFO_DEPTH)) u_mem_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (mem_valid),
    .i_entry (w_mem_in),
    .i_pop   (w_pop_mem),
    .o_head  (w_mem_head),
    .o_full  (w_mem_full),
    .o_count (w_mem_count)
  );

  assign w_alu_empty = (w_alu_count == '0);
  assign w_mem_empty = (w_mem_count == '0);
  assign w_mem_hi    = (w_mem_count >= MEM_CW'(MEM_HI_WM));

`ifdef WB_ALU_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;

  // Counts cycles the ALU head waits; saturates at the limit until granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_pop_alu) begin
      r_starve_cnt <= '0;
    end else if (!w_alu_empty && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // A full MEM FIFO still wins: overriding it there would drop MEM data.
  assign w_alu_force = (r_starve_cnt == SW'(STARVE_LIMIT)) && !w_alu_empty && !w_mem_full;
`else
  assign w_alu_force = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    w_grant = !w_alu_empty || !w_mem_empty;
    w_src   = SRC_MEM;
    if (w_alu_force)      w_src = SRC_ALU;
    else if (w_mem_hi)    w_src = SRC_MEM;
    else if (w_alu_empty) w_src = SRC_MEM;
    else if (w_mem_empty) w_src = SRC_ALU;
    else                  w_src = r_rr;
  end

  assign w_pop_alu = w_grant && (w_src == SRC_ALU);
  assign w_pop_mem = w_grant && (w_src == SRC_MEM);
  assign w_head    = (w_src == SRC_ALU) ? w_alu_head : w_mem_head;

  // Round-robin pointer always points at the side that lost the last grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rr <= SRC_ALU;
    else if (w_grant) r_rr <= other_src(w_src);
  end

  // Registered output stage; fields hold their last value between grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_write <= 1'b0;
      r_fb_valid <= 1'b0;
      r_warp     <= '0;
      r_scb      <= '0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_rf_write <= w_grant && w_head.reg_write;
      r_fb_valid <= w_grant;
      if (w_grant) begin
        r_warp <= w_head.warp_ID;
        r_scb  <= w_head.scb_ID;
        r_addr <= w_head.reg_addr;
        r_mask <= w_head.thread_mask;
        r_data <= w_head.data;
      end
      // A push into a full MEM FIFO that is not popping this cycle is lost.
      if (mem_valid && w_mem_full && !w_pop_mem) r_ovf <= 1'b1;
    end
  end

  assign rf_write_o            = r_rf_write;
  assign rf_warpID_o           = r_warp;
  assign rf_addr_o             = r_addr;
  assign rf_mask_o             = r_mask;
  assign rf_data_o             = r_data;
  assign pos_feedback_valid_o  = r_fb_valid;
  assign pos_feedback_warpID_o = r_warp;
  assign pos_feedback_scbID_o  = r_scb;
  assign pos_feedback_mask_o   = r_mask;
  assign mem_ovf_o             = r_ovf;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Self-checking bench for wb_port_arbiter. A queue-based reference model
// applies the arbitration rules to the two request streams; directed steps
// cover reset, latency, alternation, stores and watermark priority, then a
// randomized phase compares every output every cycle.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int ALU_D = 2;
  localparam int MEM_D = 4;
  localparam int HI_WM = 2;
`ifdef WB_ALU_STARVE_EN
  localparam int LIM   = 8;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, alu_ready;
  logic [WARP_W-1:0] alu_warp_ID;
  logic [SCB_W-1:0]  alu_scb_ID;
  logic [REG_W-1:0]  alu_reg_addr;
  logic [LANES-1:0]  alu_thread_mask;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_reg_write;
  logic [WARP_W-1:0] mem_warp_ID;
  logic [SCB_W-1:0]  mem_scb_ID;
  logic [REG_W-1:0]  mem_reg_addr;
  logic [LANES-1:0]  mem_thread_mask;
  logic [DATA_W-1:0] mem_data;
  logic              rf_write_o, pos_feedback_valid_o, mem_ovf_o;
  logic [WARP_W-1:0] rf_warpID_o, pos_feedback_warpID_o;
  logic [REG_W-1:0]  rf_addr_o;
  logic [LANES-1:0]  rf_mask_o, pos_feedback_mask_o;
  logic [DATA_W-1:0] rf_data_o;
  logic [SCB_W-1:0]  pos_feedback_scbID_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  wb_entry_t         alu_q[$];
  wb_entry_t         mem_q[$];
  int                rr;        // side that wins the next tie: 0 = ALU, 1 = MEM
  int                starve;
  logic              exp_rf_write, exp_fb_valid, exp_ovf;
  logic [WARP_W-1:0] exp_warp;
  logic [SCB_W-1:0]  exp_scb;
  logic [REG_W-1:0]  exp_addr;
  logic [LANES-1:0]  exp_mask;
  logic [DATA_W-1:0] exp_data;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk                   (clk),
    .reset                 (reset),
    .alu_valid             (alu_valid),
    .alu_ready             (alu_ready),
    .alu_warp_ID           (alu_warp_ID),
    .alu_scb_ID            (alu_scb_ID),
    .alu_reg_addr          (alu_reg_addr),
    .alu_thread_mask       (alu_thread_mask),
    .alu_data              (alu_data),
    .mem_valid             (mem_valid),
    .mem_reg_write         (mem_reg_write),
    .mem_warp_ID           (mem_warp_ID),
    .mem_scb_ID            (mem_scb_ID),
    .mem_reg_addr          (mem_reg_addr),
    .mem_thread_mask       (mem_thread_mask),
    .mem_data              (mem_data),
    .rf_write_o            (rf_write_o),
    .rf_warpID_o           (rf_warpID_o),
    .rf_addr_o             (rf_addr_o),
    .rf_mask_o             (rf_mask_o),
    .rf_data_o             (rf_data_o),
    .pos_feedback_valid_o  (pos_feedback_valid_o),
    .pos_feedback_warpID_o (pos_feedback_warpID_o),
    .pos_feedback_scbID_o  (pos_feedback_scbID_o),
    .pos_feedback_mask_o   (pos_feedback_mask_o),
    .mem_ovf_o             (mem_ovf_o)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    alu_q.delete();
    mem_q.delete();
    rr           = 0;
    starve       = 0;
    exp_rf_write = 1'b0;
    exp_fb_valid = 1'b0;
    exp_ovf      = 1'b0;
    exp_warp     = '0;
    exp_scb      = '0;
    exp_addr     = '0;
    exp_mask     = '0;
    exp_data     = '0;
  endtask

  // Advances the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit        alu_rdy, has_a, has_m, force_alu;
    int        win;
    wb_entry_t e;
    alu_rdy   = alu_q.size() < ALU_D;
    has_a     = alu_q.size() > 0;
    has_m     = mem_q.size() > 0;
    force_alu = 1'b0;
    win       = -1;
`ifdef WB_ALU_STARVE_EN
    force_alu = (starve >= LIM) && has_a && (mem_q.size() < MEM_D);
`endif
    if (has_a || has_m) begin
      if (force_alu)                  win = 0;
      else if (mem_q.size() >= HI_WM) win = 1;
      else if (!has_m)                win = 0;
      else if (!has_a)                win = 1;
      else                            win = rr;
      rr = 1 - win;
    end
`ifdef WB_ALU_STARVE_EN
    if (win == 0) starve = 0;
    else if (has_a && starve < LIM) starve++;
`endif
    exp_rf_write = 1'b0;
    exp_fb_valid = 1'b0;
    if (win >= 0) begin
      e = (win == 0) ? alu_q.pop_front() : mem_q.pop_front();
      exp_rf_write = e.reg_write;
      exp_fb_valid = 1'b1;
      exp_warp     = e.warp_ID;
      exp_scb      = e.scb_ID;
      exp_addr     = e.reg_addr;
      exp_mask     = e.thread_mask;
      exp_data     = e.data;
    end
    if (alu_valid && alu_rdy)
      alu_q.push_back('{warp_ID: alu_warp_ID, scb_ID: alu_scb_ID, reg_addr: alu_reg_addr,
                        thread_mask: alu_thread_mask, reg_write: 1'b1, data: alu_data});
    if (mem_valid) begin
      if (mem_q.size() < MEM_D)
        mem_q.push_back('{warp_ID: mem_warp_ID, scb_ID: mem_scb_ID, reg_addr: mem_reg_addr,
                          thread_mask: mem_thread_mask, reg_write: mem_reg_write, data: mem_data});
      else
        exp_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("rf_write",   rf_write_o,            exp_rf_write);
    check("rf_warp",    rf_warpID_o,           exp_warp);
    check("rf_addr",    rf_addr_o,             exp_addr);
    check("rf_mask",    rf_mask_o,             exp_mask);
    check("rf_data",    rf_data_o,             exp_data);
    check("fb_valid",   pos_feedback_valid_o,  exp_fb_valid);
    check("fb_warp",    pos_feedback_warpID_o, exp_warp);
    check("fb_scb",     pos_feedback_scbID_o,  exp_scb);
    check("fb_mask",    pos_feedback_mask_o,   exp_mask);
    check("alu_ready",  alu_ready,             1'(alu_q.size() < ALU_D));
    check("mem_ovf",    mem_ovf_o,             exp_ovf);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic rand_inputs(input int pa, input int pm);
    alu_valid       = ($urandom_range(99) < pa);
    alu_warp_ID     = WARP_W'($urandom);
    alu_scb_ID      = SCB_W'($urandom);
    alu_reg_addr    = REG_W'($urandom);
    alu_thread_mask = LANES'($urandom);
    mem_valid       = ($urandom_range(99) < pm);
    mem_reg_write   = 1'($urandom);
    mem_warp_ID     = WARP_W'($urandom);
    mem_scb_ID      = SCB_W'($urandom);
    mem_reg_addr    = REG_W'($urandom);
    mem_thread_mask = LANES'($urandom);
    for (int i = 0; i < LANES; i++) begin
      alu_data[i*LANE_W +: LANE_W] = $urandom;
      mem_data[i*LANE_W +: LANE_W] = $urandom;
    end
  endtask

  // Asserts reset (asynchronously, away from the edge), checks the cleared
  // outputs, then releases and checks that ALU becomes ready again.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rf_write"}, rf_write_o,           1'b0);
    check({tag, "_fb_valid"}, pos_feedback_valid_o, 1'b0);
    check({tag, "_rf_data"},  rf_data_o,            '0);
    check({tag, "_rf_addr"},  rf_addr_o,            '0);
    check({tag, "_ovf"},      mem_ovf_o,            1'b0);
    check({tag, "_ready"},    alu_ready,            1'b0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check({tag, "_rel_ready"}, alu_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    rand_inputs(0, 0);
    idle();
    model_reset();
    #2;
    do_reset("por");

    // Traffic, then a reset in the middle of it.
    repeat (20) begin
      rand_inputs(70, 60);
      tick();
    end
    do_reset("mid");
    repeat (3) tick();            // both FIFOs must be empty: no grants appear

    // Lone ALU push: result appears after the second edge.
    rand_inputs(0, 0);
    alu_valid       = 1'b1;
    alu_warp_ID     = 3'd3;
    alu_reg_addr    = 5'd7;
    alu_thread_mask = 8'hFF;
    tick();
    check("lone_early", rf_write_o, 1'b0);
    idle();
    tick();
    check("lone_rf_write", rf_write_o,            1'b1);
    check("lone_addr",     rf_addr_o,             5'd7);
    check("lone_fb_warp",  pos_feedback_warpID_o, 3'd3);
    check("lone_fb_mask",  pos_feedback_mask_o,   8'hFF);

    // Alternation: pairs of simultaneous pushes with MEM count below watermark.
    do_reset("alt");
    for (int t = 1; t <= 12; t++) begin
      if (t % 2 == 1) begin
        rand_inputs(100, 100);
        alu_warp_ID   = 3'd1;
        mem_warp_ID   = 3'd6;
        mem_reg_write = 1'b1;
      end else begin
        idle();
      end
      tick();
      if (t >= 2) check("alt_src", pos_feedback_warpID_o, (t % 2 == 0) ? 3'd1 : 3'd6);
    end
    idle();
    repeat (4) tick();
    check("alt_ovf", mem_ovf_o, 1'b0);

    // MEM store: feedback only, no RF write.
    rand_inputs(0, 100);
    mem_reg_write = 1'b0;
    mem_scb_ID    = 2'd2;
    tick();
    idle();
    tick();
    check("store_rf_write", rf_write_o,           1'b0);
    check("store_fb_valid", pos_feedback_valid_o, 1'b1);
    check("store_fb_scb",   pos_feedback_scbID_o, 2'd2);

    // Five back-to-back MEM pushes with ALU idle: all drain in order.
    for (int i = 0; i < 5; i++) begin
      rand_inputs(0, 100);
      tick();
    end
    idle();
    repeat (4) tick();
    check("burst_ovf", mem_ovf_o, 1'b0);

    // MEM held at the watermark while ALU keeps requesting.
    for (int i = 0; i < 8; i++) begin
      rand_inputs(100, 100);
      alu_warp_ID = 3'd2;
      mem_warp_ID = 3'd5;
      tick();
    end
`ifndef WB_ALU_STARVE_EN
    check("wm_alu_ready", alu_ready,             1'b0);
    check("wm_mem_wins",  pos_feedback_warpID_o, 3'd5);
    check("wm_ovf",       mem_ovf_o,             1'b0);
`endif
    idle();
    repeat (8) tick();

    // Randomized phase with varying load, including one reset mid-run.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 100; i++) begin
        case (seg)
          0:       rand_inputs(50, 50);
          1:       rand_inputs(90, 30);
          2:       rand_inputs(30, 90);
          default: rand_inputs(85, 85);
        endcase
        tick();
      end
      if (seg == 1) do_reset("rnd");
    end
    idle();
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
